// File: rtl/vga_timing.sv
// Raster timing source for the video chain: free-running pixel/line counters with sync/blank decode.
// Latency: one clock from an enabled edge to the new position; flags are registered with their counts.
// Backpressure: none; en=0 freezes every register. VGA_TIMING_FRAME_CNT_EN adds frame_start/frame_cnt.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries as 11-bit unsigned constants so every compare is same-width.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] HB_START = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VB_START = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        h_wrap;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        hblnk_nxt;
  logic        hsync_nxt;
  logic        vblnk_nxt;
  logic        vsync_nxt;

  // Next position and its flags; decoding the next value keeps flags aligned with the registered count.
  always_comb begin
    h_wrap    = (hcount_out == H_LAST);
    h_nxt     = h_wrap ? 11'd0 : hcount_out + 11'd1;
    v_nxt     = vcount_out;
    if (h_wrap) begin
      v_nxt = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
    end
    hblnk_nxt = (h_nxt >= HB_START);
    hsync_nxt = (h_nxt >= HS_START) && (h_nxt < HS_END);
    vblnk_nxt = (v_nxt >= VB_START);
    vsync_nxt = (v_nxt >= VS_START) && (v_nxt < VS_END);
  end

  // Position and flag registers; reset lands on (0,0), which is active video.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else if (en) begin
      hcount_out <= h_nxt;
      vcount_out <= v_nxt;
      hsync_out  <= hsync_nxt;
      hblnk_out  <= hblnk_nxt;
      vsync_out  <= vsync_nxt;
      vblnk_out  <= vblnk_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic frame_wrap;

  // A frame completes on the enabled edge that leaves the last pixel of the last line.
  always_comb begin
    frame_wrap = h_wrap && (vcount_out == V_LAST);
  end

  // frame_start is a true one-cycle pulse: it drops whenever en is low so a held (0,0) never repeats it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      frame_start <= en && frame_wrap;
      if (en && frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for line-level timing and a reduced-geometry instance
// for whole frames, both compared every cycle against a position-index reference model.
// Geometry of the small instance: H 16/2/4/3 (25 clocks), V 8/1/2/3 (14 lines), 350 clocks per frame.
module tb_vga_timing;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 3;
  localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
  localparam int S_VSYNC_CLKS = SVS * (SHA + SHF + SHS + SHB);

  logic clk;
  logic rst;
  logic en_b;
  logic en_s;

  logic [10:0] hcount_b, vcount_b, hcount_s, vcount_s;
  logic hsync_b, hblnk_b, vsync_b, vblnk_b;
  logic hsync_s, hblnk_s, vsync_s, vblnk_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic fs_b, fs_s;
  logic [15:0] fc_b, fc_s;
`endif

  vga_timing dut_big (
    .clk(clk), .rst(rst), .en(en_b),
    .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
    .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_start(fs_b), .frame_cnt(fc_b)
`endif
  );

  vga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_small (
    .clk(clk), .rst(rst), .en(en_s),
    .hcount_out(hcount_s), .hsync_out(hsync_s), .hblnk_out(hblnk_s),
    .vcount_out(vcount_s), .vsync_out(vsync_s), .vblnk_out(vblnk_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_start(fs_s), .frame_cnt(fc_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [25:0] vec_b = {hcount_b, vcount_b, hsync_b, hblnk_b, vsync_b, vblnk_b};
  wire [25:0] vec_s = {hcount_s, vcount_s, hsync_s, hblnk_s, vsync_s, vblnk_s};

  int checks = 0;
  int errors = 0;

  // Reference state: number of enabled edges since the last reset for each instance.
  longint p_b = 0;
  longint p_s = 0;

  // Property trackers for the small instance and the big instance's hsync width.
  logic prev_vs = 1'b0;
  logic prev_vb = 1'b0;
  int   vs_len = 0;
  int   since_rise = 0;
  bit   seen_rise = 1'b0;
  int   hs_cnt_b = 0;
  int   fs_pulses = 0;

  typedef struct {
    int         adv;
    logic [25:0] exp;
  } vec_t;

  function automatic logic [25:0] pack(int h, int v, bit hs, bit hb, bit vs, bit vb);
    return {11'(h), 11'(v), hs, hb, vs, vb};
  endfunction

  // Position from a linear pixel index, flags from the range rules.
  function automatic logic [25:0] model(longint p, int ha, int hf, int hsw, int hbp,
                                        int va, int vf, int vsw, int vbp);
    longint ht, vt, h, v;
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    h  = p % ht;
    v  = (p / ht) % vt;
    return {11'(h), 11'(v),
            (h >= ha + hf) && (h < ha + hf + hsw), h >= ha,
            (v >= va + vf) && (v < va + vf + vsw), v >= va};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_trackers();
    prev_vs = 1'b0;
    prev_vb = 1'b0;
    vs_len = 0;
    since_rise = 0;
    seen_rise = 1'b0;
  endtask

  // Advance n clock edges, then compare both instances with the model and check properties.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bit eb, es;
      eb = en_b;
      es = en_s;
      @(posedge clk);
      if (eb) p_b++;
      if (es) p_s++;
      #1;
      chk("model_big", vec_b, model(p_b, 1024, 24, 136, 160, 768, 3, 6, 29));
      chk("model_small", vec_s, model(p_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
      if (eb && hsync_b) hs_cnt_b++;
      if (vsync_s != prev_vs || vblnk_s != prev_vb) chk("vflag_change_at_h0", hcount_s, 0);
      if (es && vsync_s) vs_len++;
      if (prev_vs && !vsync_s) begin
        chk("vsync_width", vs_len, S_VSYNC_CLKS);
        vs_len = 0;
      end
      if (es) since_rise++;
      if (!prev_vb && vblnk_s) begin
        if (seen_rise) chk("frame_period", since_rise, S_FRAME);
        seen_rise = 1'b1;
        since_rise = 0;
      end
      prev_vs = vsync_s;
      prev_vb = vblnk_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_start", fs_s, es && p_s > 0 && (p_s % S_FRAME) == 0);
      chk("frame_cnt", fc_s, 16'(p_s / S_FRAME));
      chk("frame_start_big", fs_b, eb && p_b > 0 && (p_b % (1344 * 806)) == 0);
      if (fs_s) fs_pulses++;
`endif
    end
  endtask

  // Assert reset between edges and confirm outputs clear before any clock arrives.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    p_b = 0;
    p_s = 0;
    #1;
    chk("async_rst_big", vec_b, 0);
    chk("async_rst_small", vec_s, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("async_rst_fs", fs_s, 0);
    chk("async_rst_fc", fc_s, 0);
`endif
    clear_trackers();
    #1;
    rst = 1'b1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,   pack(1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{14,  pack(15, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1,   pack(16, 0, 0, 1, 0, 0)};
    tbl[3]  = '{2,   pack(18, 0, 1, 1, 0, 0)};
    tbl[4]  = '{3,   pack(21, 0, 1, 1, 0, 0)};
    tbl[5]  = '{1,   pack(22, 0, 0, 1, 0, 0)};
    tbl[6]  = '{2,   pack(24, 0, 0, 1, 0, 0)};
    tbl[7]  = '{1,   pack(0, 1, 0, 0, 0, 0)};
    tbl[8]  = '{175, pack(0, 8, 0, 0, 0, 1)};
    tbl[9]  = '{24,  pack(24, 8, 0, 1, 0, 1)};
    tbl[10] = '{1,   pack(0, 9, 0, 0, 1, 1)};
    tbl[11] = '{49,  pack(24, 10, 0, 1, 1, 1)};
    tbl[12] = '{1,   pack(0, 11, 0, 0, 0, 1)};
    tbl[13] = '{74,  pack(24, 13, 0, 1, 0, 1)};
    tbl[14] = '{1,   pack(0, 0, 0, 0, 0, 0)};
    tbl[15] = '{1,   pack(1, 0, 0, 0, 0, 0)};

    rst  = 1'b0;
    en_b = 1'b0;
    en_s = 1'b0;
    #12;
    chk("reset_big", vec_b, 0);
    chk("reset_small", vec_s, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("reset_fs", fs_s, 0);
    chk("reset_fc", fc_s, 0);
`endif
    rst = 1'b1;

    // Small instance: hand-computed positions through one full frame and its wrap.
    en_s = 1'b1;
    foreach (tbl[i]) begin
      tick(tbl[i].adv);
      chk($sformatf("table_%0d", i), vec_s, tbl[i].exp);
    end
    en_s = 1'b0;

    // Big instance: one full 1344-clock line with the horizontal decode boundaries.
    en_b = 1'b1;
    hs_cnt_b = 0;
    tick(1024);
    chk("hblnk_rise_1024", vec_b, pack(1024, 0, 0, 1, 0, 0));
    tick(24);
    chk("hsync_rise_1048", vec_b, pack(1048, 0, 1, 1, 0, 0));
    tick(135);
    chk("hsync_last_1183", vec_b, pack(1183, 0, 1, 1, 0, 0));
    tick(1);
    chk("hsync_fall_1184", vec_b, pack(1184, 0, 0, 1, 0, 0));
    tick(160);
    chk("line_wrap", vec_b, pack(0, 1, 0, 0, 0, 0));
    chk("hsync_width", hs_cnt_b, 136);

    // Freeze with en low, then resume from the held position.
    tick(500);
    en_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("frozen_500_1", vec_b, pack(500, 1, 0, 0, 0, 0));
    end
    en_b = 1'b1;
    tick(1);
    chk("resume_501", vec_b, pack(501, 1, 0, 0, 0, 0));

    // Asynchronous reset mid-line, then restart at (1,0).
    tick(199);
    chk("pre_reset_700", vec_b, pack(700, 1, 0, 0, 0, 0));
    async_reset();
    en_s = 1'b1;
    tick(1);
    chk("restart_big", vec_b, pack(1, 0, 0, 0, 0, 0));
    chk("restart_small", vec_s, pack(1, 0, 0, 0, 0, 0));
    en_b = 1'b0;

    // Random enable pattern on the small instance over several frames.
    for (int i = 0; i < 2000; i++) begin
      en_s = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    en_s = 1'b0;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Three frames from reset give three pulses and a count of three.
    tick(1);
    async_reset();
    fs_pulses = 0;
    en_s = 1'b1;
    tick(3 * S_FRAME);
    chk("frame_pulses_3", fs_pulses, 3);
    chk("frame_cnt_3", fc_s, 3);
    en_s = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
